// File: rtl/snake_field_builder_if.sv
// Frame-build bus between the movement stage (master) and the field builder (slave).
//
// Handshake: update is a one-cycle request. It is accepted only when the
// builder is idle and game_over is low. busy is high from the cycle after
// acceptance through the done cycle. There is no ready signal, so a request
// that arrives while busy is dropped. done is a one-cycle pulse. field,
// grow and game_over are valid in the done cycle. snake_xy and lengh must
// stay stable while busy is high.
interface snake_field_builder_if #(
  parameter int SIZE_X     = 10,
  parameter int SIZE_Y     = 10,
  parameter int MAX_LEN    = SIZE_X * SIZE_Y,
  parameter int SNAKE_SIZE = 16 * MAX_LEN
);
  logic                  start;
  logic                  update;
  logic [15:0]           lengh;
  logic [SNAKE_SIZE-1:0] snake_xy;
  logic [MAX_LEN-1:0]    field;
  logic [7:0]            food_x;
  logic [7:0]            food_y;
  logic                  grow;
  logic                  game_over;
  logic                  busy;
  logic                  done;

  modport master (
    output start, update, lengh, snake_xy,
    input  field, food_x, food_y, grow, game_over, busy, done
  );

  modport slave (
    input  start, update, lengh, snake_xy,
    output field, food_x, food_y, grow, game_over, busy, done
  );
endinterface

// File: rtl/snake_field_builder.sv
// Rasterises the snake segment list into an occupancy bitmap, one segment per
// clock. Detects wall and self collisions, detects the head reaching the food,
// and relocates the food to a free cell when it is eaten.
module snake_field_builder #(
  parameter int SIZE_X     = 10,
  parameter int SIZE_Y     = 10,
  parameter int MAX_LEN    = SIZE_X * SIZE_Y,
  parameter int SNAKE_SIZE = 16 * MAX_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  snake_field_builder_if.slave  io_bus,
  output logic [2:0]            o_dbg_state
);

  localparam int              CW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              SW        = $clog2(SNAKE_SIZE);
  localparam logic [15:0]     MAX_LEN16 = 16'(MAX_LEN);
  localparam logic [CW-1:0]   LAST_CELL = CW'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SCAN  = 3'd2,
    S_CHECK = 3'd3,
    S_FOOD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_pcnt;
  logic [CW-1:0]      r_cand;
  logic [15:0]        r_probe;
  logic [15:0]        r_len;
  logic [15:0]        r_idx;
  logic [MAX_LEN-1:0] r_scratch;
  logic [MAX_LEN-1:0] r_field;
  logic [7:0]         r_food_x;
  logic [7:0]         r_food_y;
  logic               r_eat;
  logic               r_coll;
  logic               r_grow;
  logic               r_game_over;

  logic [SW-1:0]      w_seg_base;
  logic [15:0]        w_seg;
  logic [7:0]         w_x;
  logic [7:0]         w_y;
  logic               w_in_field;
  logic [CW-1:0]      w_cell;
  logic               w_accept;
  logic               w_cand_free;
  logic               w_last_probe;
  logic [15:0]        w_len;

  // Current segment and its bitmap cell; only meaningful during SCAN.
  assign w_seg_base   = SW'({r_idx, 4'b0000});
  assign w_seg        = io_bus.snake_xy[w_seg_base +: 16];
  assign w_x          = w_seg[7:0];
  assign w_y          = w_seg[15:8];
  assign w_in_field   = (w_x < 8'(SIZE_X)) && (w_y < 8'(SIZE_Y));
  assign w_cell       = CW'(16'(w_y) * 16'(SIZE_X) + 16'(w_x));
  assign w_accept     = io_bus.update && !r_game_over;
  assign w_cand_free  = ~r_scratch[r_cand];
  assign w_last_probe = (r_probe == MAX_LEN16 - 16'd1);
  assign w_len        = (io_bus.lengh > MAX_LEN16) ? MAX_LEN16 : io_bus.lengh;

  // Next-state logic; rst and start override this in the register block.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_len == 16'd0) ? S_CHECK : S_SCAN;
      S_SCAN:  if (r_idx == r_len - 16'd1) w_next = S_CHECK;
      S_CHECK: w_next = (!r_coll && r_eat) ? S_FOOD : S_DONE;
      S_FOOD:  if (w_cand_free || w_last_probe) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and datapath; start behaves like rst.
  always_ff @(posedge clk) begin
    if (rst || io_bus.start) begin
      r_state     <= S_IDLE;
      r_pcnt      <= '0;
      r_cand      <= '0;
      r_probe     <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_scratch   <= '0;
      r_field     <= '0;
      r_food_x    <= 8'(SIZE_X - 1);
      r_food_y    <= 8'(SIZE_Y - 1);
      r_eat       <= 1'b0;
      r_coll      <= 1'b0;
      r_grow      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pcnt  <= (r_pcnt == LAST_CELL) ? '0 : r_pcnt + 1'b1;
      // Entering DONE publishes the frame: field and grow change together.
      if (w_next == S_DONE) begin
        r_field <= r_scratch;
        r_grow  <= r_eat;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_len  <= w_len;
            r_eat  <= 1'b0;
            r_coll <= 1'b0;
            r_grow <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_scratch <= '0;
          r_idx     <= '0;
        end
        S_SCAN: begin
          if (!w_in_field) begin
            r_coll <= 1'b1;
          end else begin
            if (r_scratch[w_cell]) r_coll <= 1'b1;
            r_scratch[w_cell] <= 1'b1;
          end
          if (r_idx == 16'd0 && w_x == r_food_x && w_y == r_food_y) r_eat <= 1'b1;
          r_idx <= r_idx + 16'd1;
        end
        S_CHECK: begin
          if (r_coll) begin
            r_game_over <= 1'b1;
          end else if (r_eat) begin
            r_cand  <= r_pcnt;
            r_probe <= '0;
          end
        end
        S_FOOD: begin
          if (w_cand_free) begin
            r_food_x <= 8'(32'(r_cand) % SIZE_X);
            r_food_y <= 8'(32'(r_cand) / SIZE_X);
          end else if (w_last_probe) begin
            r_game_over <= 1'b1;
          end else begin
            r_cand  <= (r_cand == LAST_CELL) ? '0 : r_cand + 1'b1;
            r_probe <= r_probe + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.field     = r_field;
  assign io_bus.food_x    = r_food_x;
  assign io_bus.food_y    = r_food_y;
  assign io_bus.grow      = r_grow;
  assign io_bus.game_over = r_game_over;
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.done      = (r_state == S_DONE);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_snake_field_builder.sv
// Directed bench for snake_field_builder on a 10x10 field.
module tb_snake_field_builder;
  localparam int SX = 10;
  localparam int SY = 10;
  localparam int ML = SX * SY;
  localparam logic [2:0] ST_SCAN = 3'd2;
  localparam logic [2:0] ST_FOOD = 3'd4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_field_builder_if #(.SIZE_X(SX), .SIZE_Y(SY)) bus ();
  logic [2:0] dbg_state;

  snake_field_builder #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [ML-1:0] exp_f;

  // Scoreboard check
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic set_seg(input int i, input int x, input int y);
    bus.snake_xy[16*i +: 16] = {8'(y), 8'(x)};
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Issues update in the current cycle (cycle 0) and waits for done; returns at
  // the negedge of the done cycle.
  task automatic run_frame(input string tag, input int exp_cyc);
    int  cyc;
    bit  seen;
    bus.update = 1'b1;
    @(negedge clk); bus.update = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 400 && !seen) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 128'(seen), 128'd1);
    check({tag, "_done_cycle"}, 128'(cyc), 128'(exp_cyc));
  endtask

  task automatic watch_idle(input string tag, input int n);
    bit act;
    act = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.busy || bus.done) act = 1'b1;
    end
    check(tag, 128'(act), 128'd0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.update   = 1'b0;
    bus.lengh    = 16'd0;
    bus.snake_xy = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_field", 128'(bus.field), 128'd0);
    check("rst_food_x", 128'(bus.food_x), 128'd9);
    check("rst_food_y", 128'(bus.food_y), 128'd9);
    check("rst_flags", 128'({bus.grow, bus.game_over, bus.busy, bus.done}), 128'd0);
    rst = 1'b0;

    // Basic build
    pulse_start();
    bus.lengh = 16'd4;
    set_seg(0, 3, 2); set_seg(1, 2, 2); set_seg(2, 1, 2); set_seg(3, 0, 2);
    run_frame("basic", 7);
    exp_f = '0;
    for (int b = 20; b <= 23; b++) exp_f[b] = 1'b1;
    check("basic_field", 128'(bus.field), 128'(exp_f));
    check("basic_grow_go", 128'({bus.grow, bus.game_over}), 128'd0);
    @(negedge clk);
    check("basic_busy_after", 128'({bus.busy, bus.done}), 128'd0);

    // Eat: pcnt is 0 one cycle after start; update at pcnt=97 puts 0 in CHECK
    pulse_start();
    bus.snake_xy = '0;
    bus.lengh = 16'd1;
    set_seg(0, 9, 9);
    repeat (97) @(negedge clk);
    run_frame("eat", 5);
    exp_f = '0; exp_f[99] = 1'b1;
    check("eat_field", 128'(bus.field), 128'(exp_f));
    check("eat_food", 128'({bus.food_x, bus.food_y}), 128'h0000);
    check("eat_grow", 128'(bus.grow), 128'd1);
    repeat (5) @(negedge clk);
    check("eat_grow_hold", 128'(bus.grow), 128'd1);
    set_seg(0, 5, 5);
    run_frame("noeat", 4);
    exp_f = '0; exp_f[55] = 1'b1;
    check("noeat_field", 128'(bus.field), 128'(exp_f));
    check("noeat_grow", 128'(bus.grow), 128'd0);

    // rst in the middle of a food search (food is at (0,0), field non-zero)
    @(negedge clk);
    bus.lengh = 16'd100;
    set_seg(0, 0, 0);
    for (int i = 1; i < ML; i++) set_seg(i, i % SX, i / SX);
    bus.update = 1'b1;
    @(negedge clk); bus.update = 1'b0;
    repeat (109) @(negedge clk);
    check("midfood_state", 128'(dbg_state), 128'(ST_FOOD));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midfood_field", 128'(bus.field), 128'd0);
    check("midfood_food", 128'({bus.food_x, bus.food_y}), 128'h0909);
    check("midfood_flags", 128'({bus.grow, bus.game_over, bus.busy, bus.done}), 128'd0);

    // Self collision
    pulse_start();
    bus.snake_xy = '0;
    bus.lengh = 16'd5;
    set_seg(0, 4, 4); set_seg(1, 5, 4); set_seg(2, 5, 5); set_seg(3, 4, 5); set_seg(4, 4, 4);
    run_frame("self", 8);
    check("self_go", 128'(bus.game_over), 128'd1);
    exp_f = '0; exp_f[44] = 1'b1; exp_f[45] = 1'b1; exp_f[55] = 1'b1; exp_f[54] = 1'b1;
    check("self_field", 128'(bus.field), 128'(exp_f));
    @(negedge clk); bus.update = 1'b1;
    @(negedge clk); bus.update = 1'b0;
    watch_idle("self_update_ignored", 10);
    pulse_start();
    check("self_start_clears_go", 128'(bus.game_over), 128'd0);

    // Wall
    bus.snake_xy = '0;
    bus.lengh = 16'd2;
    set_seg(0, 10, 3); set_seg(1, 9, 3);
    run_frame("wall", 5);
    check("wall_go", 128'(bus.game_over), 128'd1);
    exp_f = '0; exp_f[39] = 1'b1;
    check("wall_field", 128'(bus.field), 128'(exp_f));

    // Full field: head on food, every cell covered once
    pulse_start();
    bus.lengh = 16'd100;
    set_seg(0, 9, 9);
    for (int i = 1; i < ML; i++) set_seg(i, (i - 1) % SX, (i - 1) / SX);
    run_frame("full", 203);
    check("full_go", 128'(bus.game_over), 128'd1);
    check("full_food", 128'({bus.food_x, bus.food_y}), 128'h0909);
    check("full_field", 128'(bus.field), 128'({ML{1'b1}}));
    check("full_grow", 128'(bus.grow), 128'd1);

    // Abort: build one frame, then start during SCAN cycle 3 of the next
    pulse_start();
    bus.snake_xy = '0;
    bus.lengh = 16'd4;
    set_seg(0, 3, 2); set_seg(1, 2, 2); set_seg(2, 1, 2); set_seg(3, 0, 2);
    run_frame("pre_abort", 7);
    @(negedge clk); bus.update = 1'b1;
    @(negedge clk); bus.update = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_scan", 128'(dbg_state), 128'(ST_SCAN));
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_field", 128'(bus.field), 128'd0);
    watch_idle("abort_no_done", 10);

    // Zero length
    bus.lengh = 16'd0;
    run_frame("len0", 3);
    check("len0_field", 128'(bus.field), 128'd0);
    check("len0_go", 128'(bus.game_over), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
